scalar_rf_multiport: RTL and testbench

Parametrised scalar register file, the next generation of the 8×16 two-read/one-write scalar file. It adds a configurable read-port count, depth and width, and a synchronous reset that starts a hardware clear sweep with a `busy`/`done` handshake. It also adds a per-entry pending scoreboard for in-flight writes, and optional write-to-read bypass. It sits between decode (read addresses, lock requests) and writeback (write port) of the scalar datapath.

---
 rtl/scalar_rf_pkg.sv | 16 +
 rtl/scalar_rf_clear_seq.sv | 76 +++++++
 rtl/scalar_rf_multiport.sv | 126 ++++++++++++
 tb/tb_scalar_rf_multiport.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/scalar_rf_pkg.sv
// rtl/scalar_rf_pkg.sv - shared types and default sizing for the scalar register file
//
// Purpose: sweep FSM state type and default parameter values used by
// scalar_rf_multiport and scalar_rf_clear_seq.
package scalar_rf_pkg;

  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 8;
  localparam int NRD_DEF   = 2;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/scalar_rf_clear_seq.sv
// rtl/scalar_rf_clear_seq.sv - clear sweep sequencer (FSM, index counter, busy/done)
//
// Purpose: walks clr_idx over every entry once per sweep. A sweep starts on
// reset or on clr_req while idle; clr_req during a sweep is ignored and a
// reset mid-sweep restarts it from entry 0 without a done pulse.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   clr_req         - request a sweep (honoured only while idle)
//   busy            - high while sweeping (decoded from state)
//   done            - registered one-cycle pulse after the last entry is cleared
//   clr_active      - same as busy, for the storage array
//   clr_idx         - entry being cleared this cycle
//   clr_start       - idle-state clr_req accepted this cycle (pending bits reset)
module scalar_rf_clear_seq
  import scalar_rf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          done,
  output logic          clr_active,
  output logic [AW-1:0] clr_idx,
  output logic          clr_start
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      RF_CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = RF_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == RF_CLEAR);
  assign clr_active = busy;
  assign clr_idx    = idx_q;
  assign done       = done_q;
  assign clr_start  = (state_q == RF_IDLE) && clr_req && !rst;

endmodule

// File: rtl/scalar_rf_multiport.sv
// rtl/scalar_rf_multiport.sv - parametrised multi-read scalar register file with pending scoreboard
//
// Purpose: DEPTH x DW storage with NRD registered read ports, one write port,
// a per-entry pending bit set by lock and cleared by write, and a hardware
// clear sweep after reset or on request.
// Optional feature: define SCALAR_RF_BYPASS_EN to forward same-cycle write
// data/pending state to matching read ports.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   rd_addr, rd_data  - NRD read addresses / registered data, port k at slice k
//   rd_pend           - registered pending bit of each addressed entry
//   wr_en/addr/data   - write port (clears pending bit of the entry)
//   lock_en/addr      - mark an entry pending
//   clr_req           - request a clear sweep
//   busy, done        - sweep in progress / one-cycle completion pulse
module scalar_rf_multiport
  import scalar_rf_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int NRD   = NRD_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_pend,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              lock_en,
  input  logic [AW-1:0]     lock_addr,
  input  logic              clr_req,
  output logic              busy,
  output logic              done
);

  logic          clr_active;
  logic [AW-1:0] clr_idx;
  logic          clr_start;

  scalar_rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (clr_req),
    .busy       (busy),
    .done       (done),
    .clr_active (clr_active),
    .clr_idx    (clr_idx),
    .clr_start  (clr_start)
  );

  // Writes and locks are only honoured while idle and out of reset.
  logic wr_ok, lock_ok;
  assign wr_ok   = wr_en   && !rst && !clr_active;
  assign lock_ok = lock_en && !rst && !clr_active;

  logic [DW-1:0] mem_q [DEPTH];

  // Storage has no reset; the sweep zeroes it. A write in the same cycle as
  // an accepted clr_req still lands and is then overwritten by the sweep.
  always_ff @(posedge clk) begin
    if (clr_active) begin
      mem_q[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  logic [DEPTH-1:0] pend_q, pend_d;

  // Lock is applied after the write clear so lock wins on the same entry.
  always_comb begin
    pend_d = pend_q;
    if (clr_start) begin
      pend_d = '0;
    end else begin
      if (wr_ok)   pend_d[wr_addr]   = 1'b0;
      if (lock_ok) pend_d[lock_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] data_q;
    logic          pend_rd_q;

    assign ra = rd_addr[k*AW +: AW];

    always_ff @(posedge clk) begin
      if (rst || clr_active) begin
        data_q    <= '0;
        pend_rd_q <= 1'b0;
      end else begin
`ifdef SCALAR_RF_BYPASS_EN
        if (wr_ok && (wr_addr == ra)) begin
          data_q    <= wr_data;
          pend_rd_q <= lock_ok && (lock_addr == ra);
        end else begin
          data_q    <= mem_q[ra];
          pend_rd_q <= pend_q[ra];
        end
`else
        data_q    <= mem_q[ra];
        pend_rd_q <= pend_q[ra];
`endif
      end
    end

    assign rd_data[k*DW +: DW] = data_q;
    assign rd_pend[k]          = pend_rd_q;
  end

endmodule

// File: tb/tb_scalar_rf_multiport.sv
// tb/tb_scalar_rf_multiport.sv - directed self-checking bench for scalar_rf_multiport
module tb_scalar_rf_multiport;

  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int NRD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_pend;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              lock_en;
  logic [AW-1:0]     lock_addr;
  logic              clr_req;
  logic              busy;
  logic              done;

  int n_chk  = 0;
  int n_pass = 0;
  int busy_cnt;
  int done_cnt;
  logic [DW-1:0] exp_same;
  logic          exp_pend_same;

  always #5 clk = ~clk;

  scalar_rf_multiport dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_pend   (rd_pend),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .lock_en   (lock_en),
    .lock_addr (lock_addr),
    .clr_req   (clr_req),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd2(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    lock_en = 1'b0; lock_addr = '0; clr_req = 1'b0;

    // Reset and post-reset sweep
    step();
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_rpend", rd_pend, 0);
    rst = 1'b0;
    busy_cnt = 1;
    for (int i = 1; i < 8; i++) begin
      step();
      if (busy) busy_cnt++;
      chk("sweep_nodone", done, 0);
    end
    chk("rst_busy_len", busy_cnt, 8);
    step();
    chk("sweep9_busy", busy, 0);
    chk("sweep9_done", done, 1);
    for (int a = 0; a < 8; a++) begin
      rd2(AW'(7 - a), AW'(a));
      step();
      chk("clear_rdata", rd_data, 0);
      chk("clear_rpend", rd_pend, 0);
      if (a == 0) chk("done_one_cycle", done, 0);
    end

    // Writes then two-port read
    wr(3, 16'hBEEF); step();
    wr(5, 16'h1234); step();
    wr_en = 1'b0; rd2(5, 3); step();
    chk("rd_two_ports", rd_data, {16'h1234, 16'hBEEF});

    // Same-cycle read/write
    wr(2, 16'h1111); step();
    wr(2, 16'hA5A5); rd2(0, 2); step();
`ifdef SCALAR_RF_BYPASS_EN
    exp_same = 16'hA5A5;
`else
    exp_same = 16'h1111;
`endif
    chk("same_cycle_rw", rd_data[DW-1:0], exp_same);
    wr_en = 1'b0; step();
    chk("after_write", rd_data[DW-1:0], 16'hA5A5);

    // Scoreboard
    lock_en = 1'b1; lock_addr = 4; step();
    lock_en = 1'b0; rd2(4, 4); step();
    chk("lock_pend_both", rd_pend, 2'b11);
    wr(4, 16'h4444); step();
`ifdef SCALAR_RF_BYPASS_EN
    exp_pend_same = 1'b0;
`else
    exp_pend_same = 1'b1;
`endif
    chk("wr_pend_same", rd_pend[0], exp_pend_same);
    wr_en = 1'b0; step();
    chk("wr_clears_pend", rd_pend, 2'b00);
    chk("wr_r4_data", rd_data, {16'h4444, 16'h4444});
    wr(4, 16'h5555); lock_en = 1'b1; lock_addr = 4; step();
    wr_en = 1'b0; lock_en = 1'b0; step();
    chk("lock_wins_pend", rd_pend, 2'b11);
    chk("lock_wr_data", rd_data[DW-1:0], 16'h5555);

    // Clear handshake with re-request and dropped write mid-sweep
    wr(1, 16'h00FF); step();
    wr_en = 1'b0; rd2(4, 1); step();
    chk("r1_before_clr", rd_data[DW-1:0], 16'h00FF);
    clr_req = 1'b1; step();
    clr_req = 1'b0;
    chk("clr_busy", busy, 1);
    busy_cnt = 1; done_cnt = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 2) begin
        clr_req = 1'b1; wr(1, 16'hDEAD); lock_en = 1'b1; lock_addr = 6;
      end
      step();
      clr_req = 1'b0; wr_en = 1'b0; lock_en = 1'b0;
      if (busy) begin
        busy_cnt++;
        chk("sweep_rd_zero", rd_data, 0);
      end
      if (done) done_cnt++;
    end
    chk("clr_busy_len", busy_cnt, 8);
    chk("clr_done_cnt", done_cnt, 1);
    rd2(4, 1); step();
    chk("r1_cleared", rd_data[DW-1:0], 16'h0000);
    chk("pend_cleared", rd_pend, 2'b00);
    rd2(6, 6); step();
    chk("lock_dropped", rd_pend, 2'b00);

    // Reset mid-sweep
    clr_req = 1'b1; step();
    clr_req = 1'b0;
    done_cnt = 0;
    for (int i = 2; i <= 4; i++) begin
      step();
      if (done) done_cnt++;
    end
    rst = 1'b1; step();
    rst = 1'b0;
    chk("midrst_busy", busy, 1);
    busy_cnt = 1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    chk("midrst_busy_len", busy_cnt, 8);
    chk("midrst_done_cnt", done_cnt, 1);
    wr(7, 16'h7777); step();
    wr_en = 1'b0; rd2(7, 0); step();
    chk("post_rst_write", rd_data, {16'h7777, 16'h0000});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
